alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Iterative RV32M-style multiply/divide unit; sits beside the single-cycle integer ALU in the execute stage.
- The decoder steers M-extension ops here using funct3.
- Width is parametrised, with a valid/ready handshake on both sides and a flush input.
- The pipeline stalls on in_ready/out_valid.

Parameters:
XLEN, 32, operand/result width in bits (>= 8, power of two)
CNT_W, $clog2(XLEN+1), iteration counter width (derived, not overridden)

Ports:
clk       input   1     clock, rising edge
rst_n     input   1     asynchronous reset, active-low
flush     input   1     abort in-flight op, drop any pending result
in_valid  input   1     op1/op2/funct3 valid
in_ready  output  1     unit can accept an op
funct3    input   3     0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op1       input   XLEN  rs1 operand
op2       input   XLEN  rs2 operand
out_valid output  1     result valid
out_ready input   1     consumer accepts result
result    output  XLEN  result

Behaviour:
- Reset: one clock; reset asynchronous, active-low (rst_n). Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - result=0
  - internal registers cleared
- States:
  - IDLE: in_ready=1. Accept when in_valid&&in_ready, latching funct3, operand magnitudes and sign flags.
    - Special case (div-by-zero or signed overflow) -> DONE.
    - Otherwise -> BUSY with count=XLEN.
  - BUSY: in_ready=0. One iteration per cycle; count decrements; at count==1 the final result is formed -> DONE.
  - DONE: out_valid=1, result stable. out_ready=1 -> IDLE next cycle. No new op is accepted in DONE.
- Latency: accept at edge T.
  - Normal op: out_valid high from T+XLEN+1.
  - Special case: out_valid high from T+1.
  - Throughput is one op per XLEN+2 cycles minimum.
- Multiply (radix-2 shift-add on magnitudes, 2*XLEN product, sign corrected at end):
  - MUL: low XLEN bits.
  - MULH: high half, signed x signed.
  - MULHSU: high half, op1 signed x op2 unsigned.
  - MULHU: high half, unsigned x unsigned.
  - Negation is two's complement across the full 2*XLEN bits.
- Divide (restoring, magnitudes):
  - Quotient sign = s1^s2 for DIV. Remainder sign = sign of op1 for REM.
  - DIVU/REMU use raw operands.
- Special cases (RISC-V defined, no trap):
  - op2==0: DIV/DIVU result = all ones; REM/REMU result = op1.
  - DIV/REM with op1=1<<(XLEN-1) and op2=all ones: DIV result = op1; REM result = 0.
  - MUL ops have no special case. op2==0 for MUL follows the normal path and returns 0.
- Operands are latched at accept; changing op1/op2/funct3 afterwards has no effect.
- flush:
  - Any state -> IDLE on the next edge; out_valid=0 in that cycle.
  - A result pending in DONE is discarded.
  - flush and in_valid in the same IDLE cycle: the op is NOT accepted.
  - flush has priority over out_ready.
- out_valid stays high and result holds while out_ready=0 (backpressure); no timeout.
- Reset asserted mid-operation: immediate return to reset values; no result is produced.
- result is registered; no combinational path from op1/op2 to result or out_valid.
- in_ready is a function of state only.

Test Plan:
- MUL 7 x -3 (op2=0xFFFFFFFD) -> result 0xFFFFFFEB after 33 cycles. MULH same operands -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFFE/3 -> 0x55555554. REMU 0xFFFFFFFE/3 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF at T+1. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1. REM same operands -> 0.
- Hold out_ready=0 for 10 cycles after completion -> out_valid and result stable, in_ready=0. Raise out_ready -> in_ready=1 the next cycle.
- flush at cycle 5 of a DIV -> IDLE next cycle, no out_valid pulse. Next MUL 3x4 -> 12.
- Deassert rst_n mid-BUSY -> out_valid=0 and in_ready=1 immediately, asynchronously. Rerun with XLEN=16: MULH 0x8000 x 0x8000 -> 0x4000.

Source files
------------

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one iteration per clock, with in/out valid-ready handshakes and flush.
module alu_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(XLEN + 1);

   // Handshake: an op transfers on a clock edge where in_valid && in_ready && !flush;
   // a result transfers on an edge where out_valid && out_ready && !flush.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_W-1:0]      r_count;
   logic [2:0]            r_funct3;
   logic                  r_neg;
   logic                  r_s1;
   logic [XLEN-1:0]       r_m;
   logic [XLEN-1:0]       r_hi;
   logic [XLEN-1:0]       r_lo;
   logic [XLEN-1:0]       r_result;

   logic                  w_accept;
   logic                  w_is_div;
   logic                  w_s1;
   logic                  w_s2;
   logic [XLEN-1:0]       w_mag1;
   logic [XLEN-1:0]       w_mag2;
   logic                  w_div0;
   logic                  w_ovf;
   logic                  w_special;
   logic [XLEN-1:0]       w_spec_res;

   logic [XLEN:0]         w_sum;
   logic [XLEN-1:0]       w_hi_mul;
   logic [XLEN-1:0]       w_lo_mul;
   logic [XLEN:0]         w_rem_sh;
   logic                  w_ge;
   logic [XLEN-1:0]       w_rem_sub;
   logic [XLEN-1:0]       w_hi_div;
   logic [XLEN-1:0]       w_lo_div;
   logic [XLEN-1:0]       w_hi_nxt;
   logic [XLEN-1:0]       w_lo_nxt;
   logic [2*XLEN-1:0]     w_prod;
   logic [2*XLEN-1:0]     w_prod_fix;
   logic [XLEN-1:0]       w_q_fix;
   logic [XLEN-1:0]       w_r_fix;
   logic [XLEN-1:0]       w_final;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign result    = r_result;
   assign w_accept  = (r_state == S_IDLE) && in_valid && !flush;
   assign w_is_div  = funct3[2];

   // Signedness per funct3: MUL/MULH/DIV/REM signed x signed, MULHSU signed x unsigned.
   always_comb begin
      w_s1 = 1'b0;
      w_s2 = 1'b0;
      case (funct3)
         3'd0, 3'd1, 3'd4, 3'd6: begin
            w_s1 = op1[XLEN-1];
            w_s2 = op2[XLEN-1];
         end
         3'd2: w_s1 = op1[XLEN-1];
         default: ;
      endcase
   end

   assign w_mag1    = w_s1 ? (~op1 + 1'b1) : op1;
   assign w_mag2    = w_s2 ? (~op2 + 1'b1) : op2;
   assign w_div0    = (op2 == '0);
   assign w_ovf     = ((funct3 == 3'd4) || (funct3 == 3'd6)) &&
                      (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
   assign w_special = w_is_div && (w_div0 || w_ovf);

   always_comb begin
      w_spec_res = '0;
      case (funct3)
         3'd4:    w_spec_res = w_div0 ? '1 : op1;
         3'd5:    w_spec_res = '1;
         3'd6:    w_spec_res = w_div0 ? op1 : '0;
         3'd7:    w_spec_res = op1;
         default: w_spec_res = '0;
      endcase
   end

   // Multiply step: {hi,lo} holds partial product over the shifting multiplier.
   assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
   assign w_hi_mul = w_sum[XLEN:1];
   assign w_lo_mul = {w_sum[0], r_lo[XLEN-1:1]};

   // Divide step: hi is the partial remainder, lo shifts dividend out and quotient in.
   assign w_rem_sh  = {r_hi, r_lo[XLEN-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, r_m});
   assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_m;
   assign w_hi_div  = w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
   assign w_lo_div  = {r_lo[XLEN-2:0], w_ge};

   assign w_hi_nxt = r_funct3[2] ? w_hi_div : w_hi_mul;
   assign w_lo_nxt = r_funct3[2] ? w_lo_div : w_lo_mul;

   assign w_prod     = {w_hi_mul, w_lo_mul};
   assign w_prod_fix = r_neg ? (~w_prod + 1'b1) : w_prod;
   assign w_q_fix    = r_neg ? (~w_lo_div + 1'b1) : w_lo_div;
   assign w_r_fix    = r_s1 ? (~w_hi_div + 1'b1) : w_hi_div;

   always_comb begin
      w_final = '0;
      case (r_funct3)
         3'd0:             w_final = w_prod_fix[XLEN-1:0];
         3'd1, 3'd2, 3'd3: w_final = w_prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5:       w_final = w_q_fix;
         default:          w_final = w_r_fix;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_BUSY;
         S_BUSY:  if (r_count == CNT_W'(1)) w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= '0;
         r_funct3 <= '0;
         r_neg    <= 1'b0;
         r_s1     <= 1'b0;
         r_m      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_funct3 <= funct3;
         r_neg    <= w_s1 ^ w_s2;
         r_s1     <= w_s1;
         r_m      <= w_is_div ? w_mag2 : w_mag1;
         r_lo     <= w_is_div ? w_mag1 : w_mag2;
         r_hi     <= '0;
         r_count  <= CNT_W'(XLEN);
         if (w_special) r_result <= w_spec_res;
      end else if ((r_state == S_BUSY) && !flush) begin
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
         r_count <= r_count - CNT_W'(1);
         if (r_count == CNT_W'(1)) r_result <= w_final;
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed and random ops on XLEN=32 and XLEN=16 instances,
// checked against an arithmetic reference model.
module tb_alu_muldiv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush = 1'b0;

   logic        iv32 = 1'b0, or32 = 1'b0, ir32, ov32;
   logic [2:0]  f32 = '0;
   logic [31:0] a32 = '0, b32 = '0, res32;

   logic        iv16 = 1'b0, or16 = 1'b0, ir16, ov16;
   logic [2:0]  f16 = '0;
   logic [15:0] a16 = '0, b16 = '0, res16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_muldiv #(.XLEN(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(iv32), .in_ready(ir32), .funct3(f32), .op1(a32), .op2(b32),
      .out_valid(ov32), .out_ready(or32), .result(res32)
   );

   alu_muldiv #(.XLEN(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(iv16), .in_ready(ir16), .funct3(f16), .op1(a16), .op2(b16),
      .out_valid(ov16), .out_ready(or16), .result(res16)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // RISC-V M semantics computed with 64-bit integer arithmetic.
   function automatic logic [31:0] ref_model(input int w, input logic [2:0] f,
                                             input logic [31:0] a, input logic [31:0] b);
      longint mask, ua, ub, sa, sb, q, minv;
      logic [63:0] p;
      mask = (longint'(1) << w) - 1;
      minv = -(longint'(1) << (w - 1));
      ua = longint'(a) & mask;
      ub = longint'(b) & mask;
      sa = a[w-1] ? ua - (longint'(1) << w) : ua;
      sb = b[w-1] ? ub - (longint'(1) << w) : ub;
      case (f)
         3'd0: q = sa * sb;
         3'd1: q = (sa * sb) >>> w;
         3'd2: q = (sa * ub) >>> w;
         3'd3: begin p = ua * ub; q = longint'(p >> w); end
         3'd4: q = (ub == 0) ? -1 : ((sa == minv && sb == -1) ? sa : sa / sb);
         3'd5: q = (ub == 0) ? -1 : ua / ub;
         3'd6: q = (ub == 0) ? sa : ((sa == minv && sb == -1) ? 0 : sa % sb);
         default: q = (ub == 0) ? ua : ua % ub;
      endcase
      return 32'(q & mask);
   endfunction

   function automatic logic get_ov(input int w);
      return (w == 32) ? ov32 : ov16;
   endfunction

   function automatic logic get_ir(input int w);
      return (w == 32) ? ir32 : ir16;
   endfunction

   function automatic logic [31:0] get_res(input int w);
      return (w == 32) ? res32 : {16'h0, res16};
   endfunction

   task automatic set_in(input int w, input logic v, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b);
      if (w == 32) begin
         iv32 = v; f32 = f; a32 = a; b32 = b;
      end else begin
         iv16 = v; f16 = f; a16 = a[15:0]; b16 = b[15:0];
      end
   endtask

   task automatic set_or(input int w, input logic v);
      if (w == 32) or32 = v;
      else         or16 = v;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one op, check latency, result, optional backpressure hold and release.
   task automatic run_op(input int w, input logic [2:0] f, input logic [31:0] a_in,
                         input logic [31:0] b_in, input int hold);
      logic [31:0] mask, minv, a, b, exp, r0;
      bit          spec;
      int          lat;
      string       tag;
      mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      minv = (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
      a = a_in & mask;
      b = b_in & mask;
      exp  = ref_model(w, f, a, b);
      spec = f[2] && ((b == 0) || (!f[0] && a == minv && b == mask));
      tag  = $sformatf("w%0d f%0d %h,%h", w, f, a, b);
      lat = 0;
      while (!get_ir(w) && lat < 200) begin tick(); lat++; end
      check({tag, " ready_before"}, 32'(get_ir(w)), 32'd1);
      set_in(w, 1'b1, f, a, b);
      tick();
      set_in(w, 1'b0, 3'($urandom), $urandom, $urandom);
      check({tag, " in_ready_after_accept"}, 32'(get_ir(w)), 32'd0);
      lat = 0;
      while (!get_ov(w) && lat < 200) begin tick(); lat++; end
      check({tag, " latency"}, 32'(lat), spec ? 32'd0 : 32'(w));
      check({tag, " result"}, get_res(w), exp);
      r0 = get_res(w);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, " hold_valid"}, 32'(get_ov(w)), 32'd1);
         check({tag, " hold_result"}, get_res(w), r0);
         check({tag, " hold_in_ready"}, 32'(get_ir(w)), 32'd0);
      end
      set_or(w, 1'b1);
      tick();
      set_or(w, 1'b0);
      check({tag, " release_in_ready"}, 32'(get_ir(w)), 32'd1);
      check({tag, " release_valid"}, 32'(get_ov(w)), 32'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0000_8000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 10));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int lat;
      bit saw;

      // Asynchronous reset and reset values
      #2 rst_n = 1'b0;
      #1;
      check("reset in_ready", 32'(ir32), 32'd1);
      check("reset out_valid", 32'(ov32), 32'd0);
      check("reset result", res32, 32'd0);
      check("reset in_ready16", 32'(ir16), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Directed multiply
      run_op(32, 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
      run_op(32, 3'd1, 32'd7, 32'hFFFF_FFFD, 0);
      run_op(32, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(32, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(32, 3'd0, 32'h1234_5678, 32'h0, 0);
      // Directed divide
      run_op(32, 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(32, 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(32, 3'd5, 32'hFFFF_FFFE, 32'd3, 0);
      run_op(32, 3'd7, 32'hFFFF_FFFE, 32'd3, 0);
      // Special cases
      run_op(32, 3'd5, 32'd5, 32'd0, 0);
      run_op(32, 3'd6, 32'd5, 32'd0, 0);
      run_op(32, 3'd4, 32'd5, 32'd0, 0);
      run_op(32, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(32, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      // Backpressure hold
      run_op(32, 3'd0, 32'd123, 32'd456, 10);

      // flush together with in_valid in IDLE: not accepted
      set_in(32, 1'b1, 3'd0, 32'd3, 32'd4);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      set_in(32, 1'b0, 3'd0, 32'd0, 32'd0);
      check("flush_idle in_ready", 32'(ir32), 32'd1);
      check("flush_idle out_valid", 32'(ov32), 32'd0);

      // flush in the fifth BUSY cycle of a DIV
      set_in(32, 1'b1, 3'd4, 32'd1000, 32'd7);
      tick();
      set_in(32, 1'b0, 3'd0, 32'd0, 32'd0);
      repeat (4) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy in_ready", 32'(ir32), 32'd1);
      check("flush_busy out_valid", 32'(ov32), 32'd0);
      saw = 1'b0;
      repeat (40) begin tick(); if (ov32) saw = 1'b1; end
      check("flush_busy no_pulse", 32'(saw), 32'd0);
      run_op(32, 3'd0, 32'd3, 32'd4, 0);

      // flush while a result waits in DONE, with out_ready also high
      set_in(32, 1'b1, 3'd5, 32'd9, 32'd0);
      tick();
      set_in(32, 1'b0, 3'd0, 32'd0, 32'd0);
      check("flush_done pending", 32'(ov32), 32'd1);
      flush = 1'b1;
      or32  = 1'b1;
      tick();
      flush = 1'b0;
      or32  = 1'b0;
      check("flush_done out_valid", 32'(ov32), 32'd0);
      check("flush_done in_ready", 32'(ir32), 32'd1);

      // Reset asserted mid-BUSY
      set_in(32, 1'b1, 3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
      tick();
      set_in(32, 1'b0, 3'd0, 32'd0, 32'd0);
      repeat (10) tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy out_valid", 32'(ov32), 32'd0);
      check("rst_busy in_ready", 32'(ir32), 32'd1);
      check("rst_busy result", res32, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      lat = 0;
      saw = 1'b0;
      repeat (40) begin tick(); if (ov32) saw = 1'b1; end
      check("rst_busy no_result", 32'(saw), 32'd0);

      // XLEN=16 instance
      run_op(16, 3'd1, 32'h8000, 32'h8000, 0);
      run_op(16, 3'd4, 32'h8000, 32'hFFFF, 0);
      run_op(16, 3'd7, 32'h1234, 32'h0, 2);

      // Random ops on both widths
      for (int i = 0; i < 30; i++)
         run_op(32, 3'($urandom_range(0, 7)), pick(), pick(), 0);
      for (int i = 0; i < 15; i++)
         run_op(16, 3'($urandom_range(0, 7)), pick(), pick(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
